operand_sequencer: RTL and testbench

- Front-end input stage of the lab calculator datapath.
- Captures operand A, operand B and the opcode from the board switches, one value per button press.
- Drives the data bus and the one-hot load enables of the downstream enable-gated holding registers (A, B, opcode).
- The opcode register takes data_out[4:0] and keeps bits [2:0].
- Contains a button synchroniser/debouncer and a 4-state entry FSM.

---
 rtl/operand_sequencer_pkg.sv | 16 +
 rtl/operand_sequencer_btn_debounce.sv | 58 +++++
 rtl/operand_sequencer.sv | 108 ++++++++++
 tb/tb_operand_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/operand_sequencer_pkg.sv
// Shared types for the operand entry front-end: FSM state encoding and the
// width of the opcode field taken by the downstream opcode register.
package seq_pkg;

  // Encodings are shown on the board LEDs, so they are pinned explicitly.
  typedef enum logic [1:0] {
    ENTER_A  = 2'd0,
    ENTER_B  = 2'd1,
    ENTER_OP = 2'd2,
    SHOW     = 2'd3
  } seq_state_t;

  // The opcode register samples data_out[OPCODE_W-1:0] and keeps bits [2:0].
  localparam int OPCODE_W = 5;

endpackage

// File: rtl/operand_sequencer_btn_debounce.sv
// Push-button conditioning: 2-flop synchroniser, stable-sample debounce
// counter and rising-edge detect producing a single-cycle press strobe.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_db,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             db_prev_reg;
  logic [CNT_W-1:0] cnt_reg;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
    end
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples;
  // any sample that agrees with the current level restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_db  <= 1'b0;
      cnt_reg <= '0;
    end else if (sync2_reg != btn_db) begin
      if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        btn_db  <= sync2_reg;
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end else begin
      cnt_reg <= '0;
    end
  end

  // Delayed copy of the debounced level for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) db_prev_reg <= 1'b0;
    else     db_prev_reg <= btn_db;
  end

  // Only the press edge matters; releases are ignored.
  assign press = btn_db & ~db_prev_reg;

endmodule

// File: rtl/operand_sequencer.sv
// Operand entry front-end: steps through A, B and opcode capture on each
// debounced button press and drives the data bus plus one-hot load enables.
// Optional build macro SEQ_TIMEOUT_EN: auto-return from SHOW to ENTER_A after
// TIMEOUT_CYCLES idle cycles (parameter ignored when the macro is undefined).
module operand_sequencer
  import seq_pkg::*;
#(
  parameter int DATA_W          = 16,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_raw,
  input  logic [DATA_W-1:0] sw,
  output logic [DATA_W-1:0] data_out,
  output logic              load_a,
  output logic              load_b,
  output logic              load_op,
  output logic [1:0]        state_id,
  output logic              result_valid
);

  seq_state_t        state_reg, state_next;
  logic [DATA_W-1:0] data_next;
  logic              load_a_next, load_b_next, load_op_next;
  logic              press;
  logic              btn_level;
  logic              idle_timeout;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_raw),
    .btn_db (btn_level),
    .press  (press)
  );

`ifdef SEQ_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] idle_cnt_reg;

  // Idle counter is held at zero outside SHOW so it starts fresh on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             idle_cnt_reg <= '0;
    else if (state_reg != SHOW || press) idle_cnt_reg <= '0;
    else                                 idle_cnt_reg <= idle_cnt_reg + 1'b1;
  end

  assign idle_timeout = (state_reg == SHOW) &&
                        (idle_cnt_reg == IDLE_W'(TIMEOUT_CYCLES - 1));
`else
  assign idle_timeout = 1'b0;
`endif

  // State, data bus and load enables are all registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ENTER_A;
      data_out  <= '0;
      load_a    <= 1'b0;
      load_b    <= 1'b0;
      load_op   <= 1'b0;
    end else begin
      state_reg <= state_next;
      data_out  <= data_next;
      load_a    <= load_a_next;
      load_b    <= load_b_next;
      load_op   <= load_op_next;
    end
  end

  // Entry sequence: each press captures sw into the bus and raises one load.
  always_comb begin
    state_next   = state_reg;
    data_next    = data_out;
    load_a_next  = 1'b0;
    load_b_next  = 1'b0;
    load_op_next = 1'b0;
    case (state_reg)
      ENTER_A: if (press) begin
        state_next  = ENTER_B;
        data_next   = sw;
        load_a_next = 1'b1;
      end
      ENTER_B: if (press) begin
        state_next  = ENTER_OP;
        data_next   = sw;
        load_b_next = 1'b1;
      end
      ENTER_OP: if (press) begin
        state_next   = SHOW;
        data_next    = sw;
        load_op_next = 1'b1;
      end
      SHOW: if (press || idle_timeout) begin
        state_next = ENTER_A;
      end
      default: state_next = ENTER_A;
    endcase
  end

  assign state_id     = state_reg;
  assign result_valid = (state_reg == SHOW);

endmodule

// File: tb/tb_operand_sequencer.sv
// Scoreboard bench for operand_sequencer: stimulus pushes expected load
// transactions, a negedge monitor pops and compares each observed load.
module tb_operand_sequencer;

  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              btn_raw = 1'b0;
  logic [DATA_W-1:0] sw = '0;
  logic [DATA_W-1:0] data_out;
  logic              load_a, load_b, load_op;
  logic [1:0]        state_id;
  logic              result_valid;

  operand_sequencer #(
    .DATA_W         (DATA_W),
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .sw          (sw),
    .data_out    (data_out),
    .load_a      (load_a),
    .load_b      (load_b),
    .load_op     (load_op),
    .state_id    (state_id),
    .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]        loads;
    logic [DATA_W-1:0] data;
    logic [1:0]        state;
    int                cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0]        m_state = 2'd0;
  logic [DATA_W-1:0] m_data  = '0;
  int                last_load_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // Monitor: every load pulse must match the oldest expected transaction.
  always @(negedge clk) begin
    if (load_a || load_b || load_op) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_load: got loads=%b data=%h at cyc %0d, required none",
                 {load_op, load_b, load_a}, data_out, cyc);
      end else begin
        mon_e = sb.pop_front();
        $display("txn loads=%b data=%h state=%0d cyc=%0d",
                 {load_op, load_b, load_a}, data_out, state_id, cyc);
        check("load_vec",   {29'd0, load_op, load_b, load_a}, {29'd0, mon_e.loads});
        check("load_data",  {16'd0, data_out}, {16'd0, mon_e.data});
        check("load_state", {30'd0, state_id}, {30'd0, mon_e.state});
        check("load_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // One button press (optionally preceded by 6 cycles of bounce); the model
  // predicts the load 7 cycles after the stable rise.
  task automatic press(input logic [DATA_W-1:0] v, input bit bounce);
    int   rise;
    exp_t e;
    @(posedge clk); #1;
    sw = v;
    if (bounce) begin
      for (int i = 0; i < 6; i++) begin
        btn_raw = (i % 2 == 0);
        @(posedge clk); #1;
      end
    end
    btn_raw = 1'b1;
    rise = cyc;
    e.cyc = rise + 7;
    e.data = v;
    case (m_state)
      2'd0: begin e.loads = 3'b001; e.state = 2'd1; sb.push_back(e); m_data = v; m_state = 2'd1; end
      2'd1: begin e.loads = 3'b010; e.state = 2'd2; sb.push_back(e); m_data = v; m_state = 2'd2; end
      2'd2: begin e.loads = 3'b100; e.state = 2'd3; sb.push_back(e); m_data = v; m_state = 2'd3; end
      default: m_state = 2'd0;
    endcase
    last_load_cyc = rise + 7;
    repeat (10) @(posedge clk);
    #1;
    btn_raw = 1'b0;
    sw = ~v;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("post_state", {30'd0, state_id}, {30'd0, m_state});
    check("post_data",  {16'd0, data_out}, {16'd0, m_data});
    check("post_rv",    {31'd0, result_valid}, {31'd0, (m_state == 2'd3)});
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", {30'd0, state_id}, 32'd0);
    check("rst_data",  {16'd0, data_out}, 32'd0);
    check("rst_loads", {29'd0, load_op, load_b, load_a}, 32'd0);
    check("rst_rv",    {31'd0, result_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("idle_state", {30'd0, state_id}, 32'd0);
    check("idle_data",  {16'd0, data_out}, 32'd0);
    check("idle_loads", {29'd0, load_op, load_b, load_a}, 32'd0);

    // Round 1: clean press, bounced press, opcode, then SHOW exit by press.
    press(16'h00A5, 1'b0);
    press(16'h1234, 1'b1);
    press(16'hBEEF, 1'b0);
    press(16'h5A5A, 1'b0);

    // Round 2: full entry 3, 4, opcode 5'b10010.
    press(16'h0003, 1'b0);
    press(16'h0004, 1'b0);
    press(16'h0012, 1'b0);

`ifdef SEQ_TIMEOUT_EN
    begin
      int k = 0;
      while (state_id == 2'd3 && k < 300) begin
        @(negedge clk);
        k++;
      end
      check("timeout_cycles", cyc - last_load_cyc, 32'd50);
      check("timeout_data",   {16'd0, data_out}, 32'h0012);
      m_state = 2'd0;
    end
`else
    repeat (200) @(posedge clk);
    @(negedge clk);
    check("show_hold_state", {30'd0, state_id}, 32'd3);
    check("show_hold_rv",    {31'd0, result_valid}, 32'd1);
    press(16'h0000, 1'b0);
`endif

    // Reset during the ENTER_B press cycle discards the pending load.
    press(16'h0055, 1'b0);
    @(posedge clk); #1;
    sw = 16'h0077;
    btn_raw = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_state", {30'd0, state_id}, 32'd0);
    check("mid_rst_data",  {16'd0, data_out}, 32'd0);
    check("mid_rst_loadb", {31'd0, load_b}, 32'd0);
    btn_raw = 1'b0;
    m_state = 2'd0;
    m_data  = '0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("after_rst_state", {30'd0, state_id}, 32'd0);
    check("after_rst_data",  {16'd0, data_out}, 32'd0);
    check("sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
